// File: rtl/md_sequencer.sv
// md_sequencer: sequences the shared iterative multiply/divide unit from the
// X stage. It freezes the front of the pipeline while the unit runs, then
// presents one registered result word for injection into the X/M latch.
module md_sequencer #(
    parameter int TIMEOUT      = 40,  // max WAIT cycles before a forced exception
    parameter int MUL_EXC_CODE = 4,   // rstatus value for multiply exceptions
    parameter int DIV_EXC_CODE = 5    // rstatus value for divide exceptions
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        x_is_mul,
    input  logic        x_is_div,
    input  logic [31:0] x_operand_a,
    input  logic [31:0] x_operand_b,
    input  logic [4:0]  x_rd,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall_pipe,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_exc,
    output logic [31:0] res_exc_code
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [4:0]       EXC_RD   = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             op_div;      // latched op: 1 = divide, 0 = multiply
    logic [4:0]       rd_q;        // latched destination register
    logic [CNT_W-1:0] cnt;         // WAIT-cycle counter for the timeout

    logic             x_start;
    logic             x_div;       // mul wins when both decode flags are set
    logic             load_ops;
    logic             finish;      // entering DONE on this edge
    logic             finish_exc;  // the result being captured is an exception
    logic             finish_div;  // op that selects the exception code
    logic             stall_raw;
    logic             mult_raw;
    logic             div_raw;

    assign x_start = x_is_mul | x_is_div;
    assign x_div   = x_is_div & ~x_is_mul;

    // Next-state and control decode for the IDLE/ISSUE/WAIT/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_next = state;
        stall_raw  = 1'b0;
        mult_raw   = 1'b0;
        div_raw    = 1'b0;
        load_ops   = 1'b0;
        finish     = 1'b0;
        finish_exc = 1'b0;
        finish_div = op_div;
        case (state)
            S_IDLE: begin
                if (x_start) begin
                    stall_raw  = 1'b1;
                    load_ops   = 1'b1;
                    finish_div = x_div;
                    // Divide by zero never reaches the unit.
                    if (x_div && (x_operand_b == 32'd0)) begin
                        state_next = S_DONE;
                        finish     = 1'b1;
                        finish_exc = 1'b1;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                stall_raw  = 1'b1;
                mult_raw   = ~op_div;
                div_raw    = op_div;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                // A ready arriving on the last allowed cycle still wins over the timeout.
                if (md_ready) begin
                    state_next = S_DONE;
                    finish     = 1'b1;
                    finish_exc = md_exception;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                    finish     = 1'b1;
                    finish_exc = 1'b1;
                end
            end
            S_DONE: begin
                // The same instruction is still in D/X; it must not be reissued.
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_pipe   = stall_raw & reset;
    assign md_ctrl_mult = mult_raw & reset;
    assign md_ctrl_div  = div_raw & reset;

    // State, operand latches, timeout counter and registered result.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        // NOTE: reset clears every register, including the operand and result latches.
        if (!reset) begin
            state        <= S_IDLE;
            op_div       <= 1'b0;
            rd_q         <= 5'd0;
            md_a         <= 32'd0;
            md_b         <= 32'd0;
            cnt          <= '0;
            res_valid    <= 1'b0;
            res_data     <= 32'd0;
            res_rd       <= 5'd0;
            res_exc      <= 1'b0;
            res_exc_code <= 32'd0;
        end else begin
            state <= state_next;

            // Operands are latched once; bypass changes during the stall are ignored.
            if (load_ops) begin
                md_a   <= x_operand_a;
                md_b   <= x_operand_b;
                rd_q   <= x_rd;
                op_div <= x_div;
            end

            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CNT_ONE;
            end

            // Result registers hold a value only during DONE and read 0 otherwise.
            res_valid <= finish;
            if (finish && finish_exc) begin
                res_data     <= 32'd0;
                res_rd       <= EXC_RD;
                res_exc      <= 1'b1;
                res_exc_code <= finish_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
            end else if (finish) begin
                res_data     <= md_result;
                res_rd       <= rd_q;
                res_exc      <= 1'b0;
                res_exc_code <= 32'd0;
            end else begin
                res_data     <= 32'd0;
                res_rd       <= 5'd0;
                res_exc      <= 1'b0;
                res_exc_code <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: self-checking bench for md_sequencer. A mock unit answers
// each launch after a chosen latency; expected stall length, pulses and result
// come from plain arithmetic on the operation's rules.
module tb_md_sequencer;

    localparam int TIMEOUT  = 40;
    localparam int MUL_EXC  = 4;
    localparam int DIV_EXC  = 5;
    localparam int NEVER    = -1;

    logic        clock = 1'b0;
    logic        reset;
    logic        x_is_mul, x_is_div;
    logic [31:0] x_operand_a, x_operand_b;
    logic [4:0]  x_rd;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_a, md_b;
    logic [31:0] md_result;
    logic        md_exception, md_ready;
    logic        stall_pipe, res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_exc;
    logic [31:0] res_exc_code;

    int vectors     = 0;
    int miscompares = 0;

    md_sequencer #(
        .TIMEOUT(TIMEOUT), .MUL_EXC_CODE(MUL_EXC), .DIV_EXC_CODE(DIV_EXC)
    ) dut (
        .clock(clock), .reset(reset),
        .x_is_mul(x_is_mul), .x_is_div(x_is_div),
        .x_operand_a(x_operand_a), .x_operand_b(x_operand_b), .x_rd(x_rd),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_a(md_a), .md_b(md_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .stall_pipe(stall_pipe), .res_valid(res_valid),
        .res_data(res_data), .res_rd(res_rd), .res_exc(res_exc),
        .res_exc_code(res_exc_code)
    );

    always #5 clock = ~clock;

    // Drive inputs just after the rising edge; sample on the falling edge.
    task automatic idle_cycle(input string name);
        @(posedge clock); #1;
        x_is_mul = 1'b0; x_is_div = 1'b0; md_ready = 1'b0;
        x_operand_a = $urandom; x_operand_b = $urandom;
        @(negedge clock);
        vectors++;
        if (stall_pipe !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: stall=%b res_valid=%b, want 0/0", name, stall_pipe, res_valid);
        end
    endtask

    // One mul/div instruction entering X. k = cycles from the ctrl pulse to
    // md_ready (NEVER for no answer). The instruction stays in X through DONE.
    task automatic run_op(input string name, input bit is_mul, input bit is_div,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int k, input bit unit_exc, input bit stray,
                          output logic [31:0] got_data);
        bit          div_op    = is_div && !is_mul;
        bit          dz        = div_op && (b == 32'd0);
        bit          timed_out = !dz && (k < 1 || k > TIMEOUT);
        logic [31:0] unit_res  = div_op ? ((b != 0) ? a / b : 32'd0) : a * b;
        int          exp_stall = dz ? 1 : (timed_out ? TIMEOUT + 2 : k + 2);
        int          exp_mp    = (!dz && !div_op) ? 1 : 0;
        int          exp_dp    = (!dz && div_op) ? 1 : 0;
        bit          exp_exc   = dz || timed_out || unit_exc;
        logic [31:0] exp_data  = exp_exc ? 32'd0 : unit_res;
        logic [4:0]  exp_rd    = exp_exc ? 5'd30 : rd;
        logic [31:0] exp_code  = exp_exc ? (div_op ? 32'(DIV_EXC) : 32'(MUL_EXC)) : 32'd0;
        int  stall_cnt = 0, gaps = 0, mp = 0, dp = 0;
        bit  got = 0, ops_bad = 0, junk = 0, stall_at_valid = 0;
        logic [31:0] g_data = '0, g_code = '0;
        logic [4:0]  g_rd = '0;
        logic        g_exc = 1'b0;

        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clock); #1;
            if (c == 0) begin
                x_is_mul = is_mul; x_is_div = is_div;
                x_operand_a = a; x_operand_b = b; x_rd = rd;
            end else begin
                x_operand_a = $urandom; x_operand_b = $urandom;
            end
            if (!timed_out && !dz && c == 1 + k) begin
                md_ready = 1'b1; md_result = unit_res; md_exception = unit_exc;
            end else if (stray && c == 1) begin
                md_ready = 1'b1; md_result = $urandom; md_exception = 1'b1;
            end else begin
                md_ready = 1'b0; md_result = $urandom; md_exception = $urandom_range(0, 1);
            end
            @(negedge clock);
            if (md_ctrl_mult) mp++;
            if (md_ctrl_div) dp++;
            if ((md_ctrl_mult || md_ctrl_div) && (md_a !== a || md_b !== b)) ops_bad = 1;
            if (res_valid === 1'b1) begin
                got = 1;
                stall_at_valid = stall_pipe;
                g_data = res_data; g_rd = res_rd; g_exc = res_exc; g_code = res_exc_code;
            end else begin
                if (stall_pipe === 1'b1) stall_cnt++; else gaps++;
                if (res_data !== 0 || res_rd !== 0 || res_exc !== 0 || res_exc_code !== 0) junk = 1;
            end
        end
        md_ready = 1'b0;
        got_data = g_data;

        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s res_valid: not seen within 100 cycles", name);
        end
        vectors++;
        if (stall_cnt != exp_stall || gaps != 0 || stall_at_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s stall: %0d stall cycles, %0d gaps, stall at valid=%b; want %0d, 0, 0",
                     name, stall_cnt, gaps, stall_at_valid, exp_stall);
        end
        vectors++;
        if (mp != exp_mp || dp != exp_dp) begin
            miscompares++;
            $display("FAIL %s pulses: mult=%0d div=%0d, want mult=%0d div=%0d", name, mp, dp, exp_mp, exp_dp);
        end
        vectors++;
        if (ops_bad) begin
            miscompares++;
            $display("FAIL %s operands: md_a/md_b at pulse differ from a=%h b=%h", name, a, b);
        end
        vectors++;
        if (junk) begin
            miscompares++;
            $display("FAIL %s res_* nonzero while res_valid=0", name);
        end
        vectors++;
        if (g_data !== exp_data || g_rd !== exp_rd || g_exc !== exp_exc || g_code !== exp_code) begin
            miscompares++;
            $display("FAIL %s result: data=%h rd=%0d exc=%b code=%0d; want data=%h rd=%0d exc=%b code=%0d",
                     name, g_data, g_rd, g_exc, g_code, exp_data, exp_rd, exp_exc, exp_code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; x_is_mul = 1'b1; x_is_div = 1'b0; md_ready = 1'b1;
        x_operand_a = 32'h1234; x_operand_b = 32'h5678; x_rd = 5'd3;
        md_result = 32'hdead; md_exception = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (stall_pipe !== 0 || md_ctrl_mult !== 0 || md_ctrl_div !== 0 || res_valid !== 0 ||
            md_a !== 0 || md_b !== 0 || res_data !== 0 || res_rd !== 0 || res_exc !== 0 ||
            res_exc_code !== 0) begin
            miscompares++;
            $display("FAIL reset_state: stall=%b mult=%b div=%b valid=%b md_a=%h md_b=%h data=%h rd=%0d exc=%b code=%0d; want all 0",
                     stall_pipe, md_ctrl_mult, md_ctrl_div, res_valid, md_a, md_b, res_data, res_rd, res_exc, res_exc_code);
        end
        @(posedge clock); #1;
        reset = 1'b1; x_is_mul = 1'b0; md_ready = 1'b0;
        @(negedge clock);
        idle_cycle("reset_release");
    endtask

    task automatic test_mul_basic();
        logic [31:0] d;
        run_op("mul_7x6", 1'b1, 1'b0, 32'd7, 32'd6, 5'd9, 3, 1'b0, 1'b0, d);
        vectors++;
        if (d !== 32'd42) begin
            miscompares++;
            $display("FAIL mul_7x6 value: got %0d, want 42", d);
        end
        idle_cycle("mul_7x6_after");
    endtask

    task automatic test_div_zero();
        logic [31:0] d;
        run_op("div_by_zero", 1'b0, 1'b1, 32'd100, 32'd0, 5'd12, NEVER, 1'b0, 1'b0, d);
        idle_cycle("div_by_zero_after");
    endtask

    task automatic test_mul_exception();
        logic [31:0] d;
        run_op("mul_overflow", 1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd5, 16, 1'b1, 1'b0, d);
        idle_cycle("mul_overflow_after");
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        run_op("div_timeout", 1'b0, 1'b1, 32'd77, 32'd7, 5'd8, NEVER, 1'b0, 1'b0, d);
        run_op("mul_ready_last", 1'b1, 1'b0, 32'd11, 32'd13, 5'd2, TIMEOUT, 1'b0, 1'b0, d);
        run_op("mul_ready_late", 1'b1, 1'b0, 32'd11, 32'd13, 5'd2, TIMEOUT + 1, 1'b0, 1'b0, d);
        idle_cycle("timeout_after");
    endtask

    task automatic test_reset_mid_op();
        bit bad = 0;
        @(posedge clock); #1;
        x_is_div = 1'b1; x_operand_a = 32'd9; x_operand_b = 32'd3; x_rd = 5'd7;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (stall_pipe !== 0 || md_ctrl_mult !== 0 || md_ctrl_div !== 0 || res_valid !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_op during: stall=%b mult=%b div=%b valid=%b; want 0",
                     stall_pipe, md_ctrl_mult, md_ctrl_div, res_valid);
        end
        @(posedge clock); #1;
        reset = 1'b1; x_is_div = 1'b0;
        md_ready = 1'b1; md_result = 32'd3; md_exception = 1'b0;
        @(negedge clock);
        vectors++;
        if (stall_pipe !== 0 || res_valid !== 0 || md_a !== 0 || md_b !== 0 || res_data !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_op after: stall=%b valid=%b md_a=%h md_b=%h data=%h; want 0",
                     stall_pipe, res_valid, md_a, md_b, res_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1 md_ready = 1'b0;
            @(negedge clock);
            if (res_valid !== 0 || stall_pipe !== 0 || md_ctrl_mult !== 0 || md_ctrl_div !== 0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_mid_op stray_ready: activity seen after reset, want none");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        run_op("b2b_mul", 1'b1, 1'b0, 32'd3, 32'd5, 5'd4, 2, 1'b0, 1'b0, d1);
        run_op("b2b_div", 1'b0, 1'b1, 32'd20, 32'd4, 5'd6, 2, 1'b0, 1'b0, d2);
        vectors++;
        if (d1 !== 32'd15 || d2 !== 32'd5) begin
            miscompares++;
            $display("FAIL back_to_back values: got %0d then %0d, want 15 then 5", d1, d2);
        end
        idle_cycle("b2b_after");
    endtask

    task automatic test_random();
        logic [31:0] d, a, b;
        int sel, k;
        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 2);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            k = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 20);
            run_op("random", sel != 1, sel != 0, a, b, 5'($urandom),
                   k, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, d);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle("random_gap");
        end
    endtask

    initial begin
        x_is_mul = 0; x_is_div = 0; x_operand_a = 0; x_operand_b = 0; x_rd = 0;
        md_result = 0; md_exception = 0; md_ready = 0; reset = 0;
        test_reset();
        test_mul_basic();
        test_div_zero();
        test_mul_exception();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the shared iterative multiply/divide unit for the 5-stage pipeline.
- Detects a mul/div instruction in the X stage, freezes the front of the pipeline, and launches the unit with latched operands.
- Waits for completion or a timeout, then presents one result word, destination register and exception status for injection into the X/M latch.
- Sits beside the ALU in X; its stall output is ORed with the load-use stall.

Parameters:
- TIMEOUT, 40: max WAIT cycles before forced exception.
- MUL_EXC_CODE, 4: rstatus value on multiply overflow.
- DIV_EXC_CODE, 5: rstatus value on divide exception (incl. divide-by-zero and timeout during div).

Ports:
- clock  input  1  master clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- x_is_mul  input  1  X-stage instruction is mul (R-type, ALUop 00110)
- x_is_div  input  1  X-stage instruction is div (R-type, ALUop 00111)
- x_operand_a  input  32  bypassed ALU input A
- x_operand_b  input  32  bypassed ALU input B
- x_rd  input  5  destination register of X-stage instruction
- md_ctrl_mult  output  1  one-cycle start pulse to multiply unit
- md_ctrl_div  output  1  one-cycle start pulse to divide unit
- md_a  output  32  latched operand A to unit
- md_b  output  32  latched operand B to unit
- md_result  input  32  unit result
- md_exception  input  1  unit exception flag, valid with md_ready
- md_ready  input  1  unit result valid (single-cycle pulse)
- stall_pipe  output  1  hold PC, F/D, D/X; bubble into X/M
- res_valid  output  1  result below replaces ALU output this cycle
- res_data  output  32  result word (0 on exception)
- res_rd  output  5  destination register (30 on exception)
- res_exc  output  1  exception occurred
- res_exc_code  output  32  rstatus value when res_exc = 1, else 0

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Encoding is free. Reset forces IDLE.
- On reset: all outputs 0; md_a, md_b, result and counter registers cleared.
- x_start = x_is_mul | x_is_div. If both are high, treat as mul.
- IDLE, x_start = 0:
  - Stay in IDLE; stall_pipe = 0.
- IDLE, x_start = 1:
  - stall_pipe = 1 combinationally in the same cycle.
  - Latch A, B, rd and op.
  - If div and x_operand_b == 0: go to DONE with exception (fast path, unit never started).
  - Otherwise go to ISSUE.
- ISSUE:
  - md_ctrl_mult or md_ctrl_div = 1 for exactly this cycle (per latched op); stall_pipe = 1.
  - Clear the timeout counter; go to WAIT.
  - md_ready is ignored in ISSUE.
- WAIT:
  - stall_pipe = 1; counter increments each cycle.
  - md_ready = 1: capture md_result and md_exception, go to DONE.
  - Counter == TIMEOUT-1 without md_ready: go to DONE with exception forced.
- DONE:
  - stall_pipe = 0; res_valid = 1 for exactly this cycle; go to IDLE.
  - The same instruction is still in D/X this cycle. x_start is ignored in DONE so it is not reissued.
- Exception result:
  - res_data = 0, res_rd = 30, res_exc = 1.
  - res_exc_code = MUL_EXC_CODE or DIV_EXC_CODE according to the latched op.
- Normal result:
  - res_data = captured md_result, res_rd = latched rd, res_exc = 0, res_exc_code = 0.
- res_* outputs are registered and held stable across DONE; they read 0 whenever res_valid = 0.
- Latency: unit asserts md_ready k >= 1 cycles after the ctrl pulse → stall_pipe high for exactly k+2 consecutive cycles, then res_valid for 1 cycle.
- Latency, div-by-zero fast path: stall 1 cycle, then DONE.
- Operands are latched once. Bypass changes during the stall do not affect md_a/md_b.
- md_ready outside WAIT is ignored and causes no state change.
- Reset mid-operation: return to IDLE next edge with no pulse and no res_valid. A late md_ready afterwards is ignored.
- Back-to-back mul/div: the second instruction enters X in the cycle after DONE. It is detected in IDLE and stall reasserts with no gap cycle lost.

Test Plan:
- mul A=7, B=6; unit ready k=3 after pulse, result 42 → md_ctrl_mult one pulse; stall 5 cycles; res_valid 1 cycle with res_data=42, res_rd=x_rd, res_exc=0.
- div A=100, B=0 → no md_ctrl_div pulse; stall 1 cycle; res_valid with res_data=0, res_rd=30, res_exc_code=5.
- mul A=0x40000000, B=4; md_exception=1 with ready at k=16 → res_data=0, res_rd=30, res_exc_code=4; stall 18 cycles.
- div issued, md_ready never asserted → DONE after 1+1+TIMEOUT cycles (42 stall cycles); res_exc=1, res_exc_code=5.
- reset low during WAIT, then md_ready pulse → IDLE, all outputs 0, no res_valid; stray md_ready ignored.
- back-to-back mul (A=3, B=5 → 15) then div (A=20, B=4 → 5), k=2 each → two separate pulses; stall 4 cycles each; res_valid 15 then 5 with one non-stall cycle between.
